// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event path: FSM state encoding,
// key-count constants and the code-to-one-hot decode.
package keypad_pkg;

  localparam int NUM_KEYS = 8;
  localparam int CODE_W   = 3;

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} kd_state_t;

  function automatic logic [NUM_KEYS-1:0] onehot8(input logic [CODE_W-1:0] code);
    logic [NUM_KEYS-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchroniser for a W-bit bus crossing into the clk domain.
// Every stage clears on reset so the downstream FSM starts from a known "no key" view.
module sync_chain #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_p [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[STAGES-1];

endmodule

// File: rtl/key_event_decoder.sv
// Synchronises and debounces the priority-encoder output, producing a held-key
// one-hot, press/release pulses and a press-toggled channel enable mask.
module key_event_decoder
  import keypad_pkg::*;
#(
  parameter int                  DEBOUNCE_CYCLES = 4,
  parameter int                  SYNC_STAGES     = 2,
  parameter logic [NUM_KEYS-1:0] MASK_INIT       = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                strobe_in,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [CODE_W-1:0]   press_code,
  output logic [NUM_KEYS-1:0] chan_en
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CODE_W:0]   sync_p1;
  logic [CODE_W-1:0] s_code;
  logic              s_stb;

  kd_state_t           state_q, state_d;
  logic [CODE_W-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] onehot_d, chan_d;
  logic                press_d, rel_d;
  logic [CODE_W-1:0]   pcode_d;

  // Stage p0 -> p1: bring {code,strobe} into the clk domain
  sync_chain #(.W(CODE_W + 1), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({code_in, strobe_in}),
    .dout  (sync_p1)
  );

  assign s_code = sync_p1[CODE_W:1];
  assign s_stb  = sync_p1[0];

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    onehot_d = key_onehot;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    pcode_d  = press_code;
    chan_d   = chan_en;
    case (state_q)
      IDLE: begin
        if (s_stb) begin
          state_d = ARM;
          cap_d   = s_code;
          cnt_d   = CNT_ONE;
        end
      end
      ARM: begin
        if (!s_stb) begin
          state_d = IDLE;
        end else if (s_code != cap_q) begin
          cap_d = s_code;
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HELD;
          press_d  = 1'b1;
          onehot_d = onehot8(cap_q);
          pcode_d  = cap_q;
          chan_d   = chan_en ^ onehot8(cap_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_stb) begin
          state_d = REL;
          cnt_d   = CNT_ONE;
        end else if (s_code != cap_q) begin
          // a higher-priority key has taken over the encoder
          state_d  = ARM;
          cap_d    = s_code;
          cnt_d    = CNT_ONE;
          onehot_d = '0;
          rel_d    = 1'b1;
        end
      end
      REL: begin
        if (s_stb && (s_code == cap_q)) begin
          state_d = HELD;
        end else if (s_stb) begin
          state_d  = ARM;
          cap_d    = s_code;
          cnt_d    = CNT_ONE;
          onehot_d = '0;
          rel_d    = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          onehot_d = '0;
          rel_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1 -> p2: registered FSM state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cap_q         <= '0;
      cnt_q         <= '0;
      key_onehot    <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_code    <= '0;
      chan_en       <= MASK_INIT;
    end else begin
      state_q       <= state_d;
      cap_q         <= cap_d;
      cnt_q         <= cnt_d;
      key_onehot    <= onehot_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      press_code    <= pcode_d;
      chan_en       <= chan_d;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed and randomized bench for key_event_decoder against a run-length
// reference model of the synced key stream.
module tb_key_event_decoder;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] code_in = '0;
  logic       strobe_in = 1'b0;
  logic [7:0] key_onehot;
  logic       press_pulse;
  logic       release_pulse;
  logic [2:0] press_code;
  logic [7:0] chan_en;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  key_event_decoder #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .MASK_INIT(8'hFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .code_in       (code_in),
    .strobe_in     (strobe_in),
    .key_onehot    (key_onehot),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_code    (press_code),
    .chan_en       (chan_en)
  );

  // Reference model: held key (-1 = none), run length of identical high
  // samples, run length of low samples, all on the delayed input stream.
  logic [3:0] mq[$];
  int         m_held, m_run_len, m_low_len;
  logic [2:0] m_run_code, m_pcode;
  logic [7:0] m_chan;
  logic       e_press, e_rel;

  function automatic logic [7:0] key_bit(input int k);
    return (k < 0) ? 8'h00 : (8'h01 << k);
  endfunction

  task automatic model_step(input logic r, input logic [2:0] c, input logic s);
    logic [3:0] smp;
    logic [2:0] sc;
    logic       ss;
    e_press = 1'b0;
    e_rel   = 1'b0;
    if (r) begin
      mq = {};
      for (int i = 0; i < S; i++) mq.push_back(4'h0);
      m_held = -1; m_run_len = 0; m_low_len = 0; m_run_code = '0;
      m_pcode = '0; m_chan = 8'hFF;
      return;
    end
    mq.push_back({c, s});
    smp = mq.pop_front();
    sc  = smp[3:1];
    ss  = smp[0];
    if (ss) begin
      if (m_run_len > 0 && sc == m_run_code) m_run_len++;
      else begin m_run_code = sc; m_run_len = 1; end
      m_low_len = 0;
    end else begin
      m_run_len = 0;
      m_low_len++;
    end
    if (m_held >= 0) begin
      if ((ss && int'(sc) != m_held) || (!ss && m_low_len == D)) begin
        e_rel  = 1'b1;
        m_held = -1;
      end
    end else if (m_run_len == D) begin
      e_press = 1'b1;
      m_held  = int'(sc);
      m_pcode = sc;
      m_chan  = m_chan ^ key_bit(m_held);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [2:0] c, input logic s);
    @(negedge clk);
    reset = r; code_in = c; strobe_in = s;
    @(posedge clk);
    #1;
    model_step(r, c, s);
    check("key_onehot", key_onehot, key_bit(m_held));
    check("press_pulse", {7'd0, press_pulse}, {7'd0, e_press});
    check("release_pulse", {7'd0, release_pulse}, {7'd0, e_rel});
    check("press_code", {5'd0, press_code}, {5'd0, m_pcode});
    check("chan_en", chan_en, m_chan);
    check("no_coincident_pulses", {7'd0, press_pulse & release_pulse}, 8'h00);
  endtask

  task automatic hold(input logic [2:0] c, input logic s, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, c, s);
  endtask

  initial begin
    int len;
    logic r, s;
    logic [2:0] c;

    // reset state
    tick(1'b1, 3'd0, 1'b0);
    tick(1'b1, 3'd0, 1'b0);
    check("reset_chan_en", chan_en, 8'hFF);
    check("reset_onehot", key_onehot, 8'h00);

    // 1: key 5 press, pulse exactly at edge 6
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 3'd5, 1'b1);
      check("t1_press_edge", {7'd0, press_pulse}, {7'd0, (i == 6)});
    end
    check("t1_onehot", key_onehot, 8'h20);
    check("t1_press_code", {5'd0, press_code}, 8'd5);
    check("t1_chan_en", chan_en, 8'hDF);
    hold(3'd5, 1'b0, 10);
    check("t1_released", key_onehot, 8'h00);

    // 2: short glitch of key 2 is rejected
    hold(3'd2, 1'b1, 3);
    hold(3'd2, 1'b0, 10);
    check("t2_onehot", key_onehot, 8'h00);
    check("t2_chan_en", chan_en, 8'hDF);

    // 3: release bounce on held key 5
    hold(3'd5, 1'b1, 10);
    check("t3_onehot_held", key_onehot, 8'h20);
    hold(3'd5, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 3'd5, 1'b1);
      check("t3_onehot_bounce", key_onehot, 8'h20);
      check("t3_no_release", {7'd0, release_pulse}, 8'h00);
    end
    hold(3'd5, 1'b0, 10);

    // 4: key 3 held, key 7 takes over
    hold(3'd3, 1'b1, 10);
    check("t4_chan_en_3", chan_en, 8'hF7);
    hold(3'd7, 1'b1, 10);
    check("t4_onehot_7", key_onehot, 8'h80);
    check("t4_chan_en_7", chan_en, 8'h77);
    hold(3'd7, 1'b0, 10);

    // 5: key 0 pressed and released twice
    hold(3'd0, 1'b1, 10);
    check("t5_chan0_off", {7'd0, chan_en[0]}, 8'h00);
    hold(3'd0, 1'b0, 10);
    hold(3'd0, 1'b1, 10);
    check("t5_chan0_on", {7'd0, chan_en[0]}, 8'h01);
    hold(3'd0, 1'b0, 10);

    // 6: reset while arming and while held
    hold(3'd4, 1'b1, 3);
    tick(1'b1, 3'd4, 1'b1);
    check("t6_arm_chan_en", chan_en, 8'hFF);
    hold(3'd4, 1'b1, 10);
    check("t6_held_onehot", key_onehot, 8'h10);
    tick(1'b1, 3'd4, 1'b1);
    check("t6_held_reset_onehot", key_onehot, 8'h00);
    check("t6_held_reset_chan_en", chan_en, 8'hFF);
    hold(3'd4, 1'b0, 6);

    // randomized segments, including glitches shorter than the debounce window
    for (int seg = 0; seg < 150; seg++) begin
      r   = ($urandom_range(0, 40) == 0);
      c   = 3'($urandom_range(0, 7));
      s   = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 9);
      tick(r, c, s);
      hold(c, s, len - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
